nap_timer_ctrl: RTL
===================

# nap_timer_ctrl

Button-driven countdown controller for the nap timer. It converts three raw button levels into single-cycle press pulses and sequences the countdown with an FSM (idle, set, run, pause, alarm). It produces the minutes/seconds remaining, a state code, `running` and `alarm`. It sits between the board push-buttons and the display/buzzer drivers.

## Interface
- `TICKS_PER_SEC`, 100, clk cycles per countdown second (≥2)
- `DEFAULT_MIN`, 20, minutes loaded on entry to SET (1..MAX_MIN)
- `MAX_MIN`, 99, highest settable minute value (≤127)
- `ALARM_SEC`, 30, seconds the alarm stays active without a press (≥1)
- `SNOOZE_MIN`, 5, minutes reloaded by snooze (only with NAP_SNOOZE_EN)

- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `btn_mode`  in  1  mode/cancel button level
- `btn_up`  in  1  increment/snooze button level
- `btn_start`  in  1  start/pause button level
- `min_remain`  out  7  minutes remaining
- `sec_remain`  out  6  seconds remaining (0..59)
- `state`  out  3  IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4
- `running`  out  1  high when state==RUN
- `alarm`  out  1  high when state==ALARM

## Operation
- Press detection per button: `prev` register; `press = level & ~prev`. `prev` resets to 1, so a button held through reset gives no press until it is released and pressed again.
- Simultaneous presses: only one acts. Priority is mode > start > up.
- IDLE:
  - mode → SET, min=DEFAULT_MIN, sec=0.
  - other buttons are ignored.
- SET:
  - up → min+1, wrapping MAX_MIN→1.
  - start → RUN, prescaler cleared.
  - mode → IDLE, min=sec=0.
- RUN:
  - Each tick (prescaler==TICKS_PER_SEC-1) decrements the time: sec 0→59 with min-1, otherwise sec-1.
  - A tick at 0:01 writes 0:00 and enters ALARM on the same edge.
  - start → PAUSE.
  - mode → IDLE, time cleared.
  - up is ignored.
- PAUSE:
  - Prescaler and time are held.
  - start → RUN, prescaler resumes from its held value.
  - mode → IDLE, time cleared.
  - up is ignored.
- ALARM:
  - Prescaler and alarm-second counter are cleared on entry. After ALARM_SEC ticks → IDLE.
  - mode or start → IDLE.
  - up → IDLE (snooze behaviour: see Configuration).
  - Time reads 0:00 throughout.
- A button press on the same edge as a tick takes precedence; the tick is discarded.
- Undefined state codes recover to IDLE.

## Timing
- Reset (async assert, sync release): state=IDLE, min_remain=0, sec_remain=0, running=0, alarm=0, prescaler=0, prev=1.
- A press acts at the first rising edge where the level is sampled high after being sampled low. All outputs update on that edge (zero added latency; all outputs registered).
- First RUN tick: the TICKS_PER_SEC-th edge after the RUN-entry edge.
- Reset mid-RUN or mid-ALARM: outputs return to reset values immediately (async). No pulse is generated on release.
- Counter widths: prescaler $clog2(TICKS_PER_SEC); alarm-second counter $clog2(ALARM_SEC+1).

## Configuration
- `NAP_SNOOZE_EN` defined: up in ALARM → RUN with min=SNOOZE_MIN, sec=0, prescaler cleared, alarm dropped on that edge.
- `NAP_SNOOZE_EN` undefined: up in ALARM → IDLE like the other buttons. No SNOOZE_MIN logic exists, and the parameter is unused.

## Structure
- Shared package `nap_pkg`: state code constants (ST_IDLE..ST_ALARM), state width, and the 7/6-bit time widths. The display driver uses the same constants.
- One sub-module, `btn_press`: per-button `prev` register plus press output, instantiated three times.
- The FSM, prescaler, time counters and alarm timer live in `nap_timer_ctrl`.

## Test plan
All cases use TICKS_PER_SEC=4, DEFAULT_MIN=1, MAX_MIN=3, ALARM_SEC=2.
- Reset with btn_start held high, then release rst → no state change until btn_start goes low then high. All outputs 0 during reset.
- mode press, then up ×3 → min_remain 2, 3, 1 (wrap); state=SET, sec_remain=0.
- From SET 1:00, press start → running=1; sec_remain=59 at the 4th edge; state=ALARM and alarm=1 at the 240th edge with time 0:00; state=IDLE 8 edges after that.
- Press start in RUN at 0:45 after 2 prescaler counts, wait 20 cycles, press start again → time stays 0:45 while paused; next decrement occurs 2 edges after resume.
- mode and start pressed on the same edge in RUN → state=IDLE, time 0:00 (mode wins). up and start pressed together in SET → RUN with min unchanged.
- In ALARM press up → with NAP_SNOOZE_EN: state=RUN, time from the spec'd SNOOZE_MIN (set to 2 → 2:00), alarm=0 same edge. Without NAP_SNOOZE_EN: state=IDLE.

Source files
------------

// File: rtl/nap_pkg.sv
// nap_pkg: state codes and time-field widths shared by the nap timer controller and its display driver.
package nap_pkg;
    localparam int ST_W  = 3;
    localparam int MIN_W = 7;
    localparam int SEC_W = 6;
    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_e;
endpackage

// File: rtl/nap_timer_ctrl_if.sv
// nap_timer_ctrl_if: button levels in, countdown time/status out.
interface nap_timer_ctrl_if;
    import nap_pkg::*;
    logic             btn_mode;
    logic             btn_up;
    logic             btn_start;
    logic [MIN_W-1:0] min_remain;
    logic [SEC_W-1:0] sec_remain;
    logic [ST_W-1:0]  state;
    logic             running;
    logic             alarm;
    modport master (output btn_mode, btn_up, btn_start, input min_remain, sec_remain, state, running, alarm);
    modport slave  (input btn_mode, btn_up, btn_start, output min_remain, sec_remain, state, running, alarm);
endinterface

// File: rtl/nap_timer_ctrl_btn_press.sv
// btn_press: one-cycle press pulse from a raw level; prev resets high so a level held through reset is not a press.
module btn_press (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press
);
    logic prev_q, prev_d;
    always_comb prev_d = level;
    assign press = level & ~prev_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) prev_q <= 1'b1;
        else     prev_q <= prev_d;
endmodule

// File: rtl/nap_timer_ctrl.sv
// nap_timer_ctrl: button-driven countdown FSM (idle/set/run/pause/alarm) with prescaler and alarm timeout.
// Define NAP_SNOOZE_EN to make "up" during ALARM restart the countdown at SNOOZE_MIN minutes.
module nap_timer_ctrl
    import nap_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int DEFAULT_MIN   = 20,
    parameter int MAX_MIN       = 99,
    parameter int ALARM_SEC     = 30,
    parameter int SNOOZE_MIN    = 5
) (
    input logic             clk,
    input logic             rst,
    nap_timer_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int AW = $clog2(ALARM_SEC + 1);
    logic p_mode, p_up, p_start, tick;
    state_e           state_q, state_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [AW-1:0]    asec_q, asec_d;
    logic             running_q, running_d, alarm_q, alarm_d;
    btn_press u_mode  (.clk(clk), .rst(rst), .level(bus.btn_mode),  .press(p_mode));
    btn_press u_up    (.clk(clk), .rst(rst), .level(bus.btn_up),    .press(p_up));
    btn_press u_start (.clk(clk), .rst(rst), .level(bus.btn_start), .press(p_start));
    assign tick = pre_q == PW'(TICKS_PER_SEC - 1);
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        pre_d   = pre_q;
        asec_d  = asec_q;
        case (state_q)
            ST_IDLE: if (p_mode) begin
                state_d = ST_SET;
                min_d   = MIN_W'(DEFAULT_MIN);
                sec_d   = '0;
            end
            ST_SET: begin
                if (p_mode) begin
                    state_d = ST_IDLE;
                    min_d   = '0;
                    sec_d   = '0;
                end else if (p_start) begin
                    state_d = ST_RUN;
                    pre_d   = '0;
                end else if (p_up) min_d = (min_q == MIN_W'(MAX_MIN)) ? MIN_W'(1) : min_q + 1'b1;
            end
            ST_RUN: begin
                if (p_mode) begin
                    state_d = ST_IDLE;
                    min_d   = '0;
                    sec_d   = '0;
                    pre_d   = '0;
                end else if (p_start) state_d = ST_PAUSE;
                else if (tick) begin
                    pre_d = '0;
                    // last second expires straight into ALARM so 0:00 never shows while running
                    if (min_q == '0 && sec_q <= SEC_W'(1)) begin
                        state_d = ST_ALARM;
                        sec_d   = '0;
                        asec_d  = '0;
                    end else begin
                        sec_d = (sec_q == '0) ? SEC_W'(59) : sec_q - 1'b1;
                        min_d = (sec_q == '0) ? min_q - 1'b1 : min_q;
                    end
                end else pre_d = pre_q + 1'b1;
            end
            ST_PAUSE: begin
                if (p_mode) begin
                    state_d = ST_IDLE;
                    min_d   = '0;
                    sec_d   = '0;
                    pre_d   = '0;
                end else if (p_start) state_d = ST_RUN;
            end
            ST_ALARM: begin
`ifdef NAP_SNOOZE_EN
                if (p_mode | p_start) begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                end else if (p_up) begin
                    state_d = ST_RUN;
                    min_d   = MIN_W'(SNOOZE_MIN);
                    sec_d   = '0;
                    pre_d   = '0;
                end else
`else
                if (p_mode | p_start | p_up) begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                end else
`endif
                if (tick) begin
                    pre_d   = '0;
                    state_d = (asec_q == AW'(ALARM_SEC - 1)) ? ST_IDLE : ST_ALARM;
                    asec_d  = asec_q + 1'b1;
                end else pre_d = pre_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                min_d   = '0;
                sec_d   = '0;
                pre_d   = '0;
                asec_d  = '0;
            end
        endcase
        running_d = state_d == ST_RUN;
        alarm_d   = state_d == ST_ALARM;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= ST_IDLE;
            min_q     <= '0;
            sec_q     <= '0;
            pre_q     <= '0;
            asec_q    <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            pre_q     <= pre_d;
            asec_q    <= asec_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    assign bus.state      = state_q;
    assign bus.min_remain = min_q;
    assign bus.sec_remain = sec_q;
    assign bus.running    = running_q;
    assign bus.alarm      = alarm_q;
endmodule
